// File: rtl/fp_pkg.sv
// ============================================================================
// Module   : fp_pkg
// Purpose  : Shared FP widths, status/flag indices and canonical encodings.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package fp_pkg;

    localparam int ST_NAN     = 3;
    localparam int ST_INF     = 2;
    localparam int ST_ZERO    = 1;
    localparam int ST_INVALID = 0;

    localparam int FL_INVALID   = 4;
    localparam int FL_OVERFLOW  = 3;
    localparam int FL_UNDERFLOW = 2;
    localparam int FL_INEXACT   = 1;
    localparam int FL_NAN       = 0;

    function automatic int exp_width(input int is_double);
        return (is_double != 0) ? 11 : 8;
    endfunction

    function automatic int mant_width(input int is_double);
        return (is_double != 0) ? 52 : 23;
    endfunction

    // Canonical quiet NaN, right-aligned in a 64-bit container.
    function automatic logic [63:0] qnan_word(input int is_double);
        return (is_double != 0) ? 64'h7FF8_0000_0000_0000 : 64'h0000_0000_7FC0_0000;
    endfunction

    typedef struct packed {
        logic       sign;
        logic       guard;
        logic       sticky;
        logic [3:0] status;
    } s1_ctrl_t;

endpackage

`default_nettype wire

// File: rtl/fp_round_nearest_even.sv
// ============================================================================
// Module   : fp_round_nearest_even
// Purpose  : Combinational round-to-nearest-even increment of a significand.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fp_round_nearest_even #(
    parameter int WIDTH = 24
) (
    input  logic [WIDTH-1:0] sig_in,
    input  logic             guard,
    input  logic             sticky,
    output logic [WIDTH-1:0] sig_out,
    output logic             carry
);

    logic inc;

    assign inc              = guard && (sticky || sig_in[0]);
    assign {carry, sig_out} = {1'b0, sig_in} + {{WIDTH{1'b0}}, inc};

endmodule

`default_nettype wire

// File: rtl/fp_mul_result_packer.sv
// ============================================================================
// Module   : fp_mul_result_packer
// Purpose  : 2-stage normalize / RNE round / IEEE pack for the FP multiplier.
//            Optional gradual underflow: FP_MUL_SUBNORMAL_OUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fp_mul_result_packer
    import fp_pkg::*;
#(
    parameter int IS_DOUBLE  = 0,
    parameter int EXP_WIDTH  = exp_width(IS_DOUBLE),
    parameter int MANT_WIDTH = mant_width(IS_DOUBLE)
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [3:0]                      in_status,
    input  logic                            in_sign,
    input  logic [EXP_WIDTH+1:0]            in_exp,
    input  logic [2*MANT_WIDTH+1:0]         in_mant,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [EXP_WIDTH+MANT_WIDTH:0]   out_result,
    output logic [4:0]                      out_flags
);

    localparam int EW = EXP_WIDTH;
    localparam int MW = MANT_WIDTH;
    localparam int RW = EW + MW + 1;
    localparam int PW = 2 * MW + 2;

    localparam logic [63:0]   QNAN64 = qnan_word(IS_DOUBLE);
    localparam logic [RW-1:0] QNAN   = QNAN64[RW-1:0];
    localparam logic [EW+1:0] E_ZERO = '0;
    localparam logic [EW+1:0] E_MAX  = (EW+2)'((1 << EW) - 1);

    logic            s1_valid_q, s1_valid_d;
    logic            s2_valid_q, s2_valid_d;
    logic [EW+1:0]   s1_exp_q, s1_exp_d;
    logic [MW:0]     s1_sig_q, s1_sig_d;
    s1_ctrl_t        s1_ctrl_q, s1_ctrl_d;
    logic [RW-1:0]   out_result_q, out_result_d;
    logic [4:0]      out_flags_q, out_flags_d;

    logic            in_fire;
    logic            s2_load;

    logic [MW:0]     rnd_sig_in, rnd_sig_out, sig_rnd;
    logic            rnd_g, rnd_s, rnd_carry, inexact;
    logic [EW+1:0]   e_rnd;

    // Look-ahead ready: stage 1 can always take a beat if anything downstream moves.
    assign in_ready = !s1_valid_q || !s2_valid_q || out_ready;
    assign in_fire  = in_valid && in_ready;
    assign s2_load  = !s2_valid_q || out_ready;

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_exp_d   = s1_exp_q;
        s1_sig_d   = s1_sig_q;
        s1_ctrl_d  = s1_ctrl_q;
        if (in_fire) begin
            s1_valid_d = 1'b1;
        end else if (s2_load) begin
            s1_valid_d = 1'b0;
        end
        if (in_fire) begin
            s1_ctrl_d.sign   = in_sign;
            s1_ctrl_d.status = in_status;
            if (in_mant[PW-1]) begin
                s1_sig_d         = in_mant[PW-1 -: MW+1];
                s1_ctrl_d.guard  = in_mant[MW];
                s1_ctrl_d.sticky = |in_mant[MW-1:0];
                s1_exp_d         = in_exp + (EW+2)'(1);
            end else begin
                s1_sig_d         = in_mant[PW-2 -: MW+1];
                s1_ctrl_d.guard  = in_mant[MW-1];
                s1_ctrl_d.sticky = |in_mant[MW-2:0];
                s1_exp_d         = in_exp;
            end
        end
    end

`ifdef FP_MUL_SUBNORMAL_OUT_EN
    localparam logic [EW+1:0] SH_MAX = (EW+2)'(MW + 2);

    logic              tiny;
    logic [EW+1:0]     sh_raw, sh_amt;
    logic [2*MW+3:0]   sh_vec;

    // Denormalize {sig, G} right by 1-e; everything shifted past G folds into S.
    always_comb begin
        tiny   = $signed(s1_exp_q) <= $signed(E_ZERO);
        sh_raw = (EW+2)'(1) - s1_exp_q;
        sh_amt = (sh_raw > SH_MAX) ? SH_MAX : sh_raw;
        sh_vec = {s1_sig_q, s1_ctrl_q.guard, {(MW+2){1'b0}}} >> sh_amt;
        if (tiny) begin
            rnd_sig_in = sh_vec[2*MW+3 : MW+3];
            rnd_g      = sh_vec[MW+2];
            rnd_s      = s1_ctrl_q.sticky | (|sh_vec[MW+1:0]);
        end else begin
            rnd_sig_in = s1_sig_q;
            rnd_g      = s1_ctrl_q.guard;
            rnd_s      = s1_ctrl_q.sticky;
        end
    end
`else
    always_comb begin
        rnd_sig_in = s1_sig_q;
        rnd_g      = s1_ctrl_q.guard;
        rnd_s      = s1_ctrl_q.sticky;
    end
`endif

    fp_round_nearest_even #(
        .WIDTH   (MW + 1)
    ) u_round (
        .sig_in  (rnd_sig_in),
        .guard   (rnd_g),
        .sticky  (rnd_s),
        .sig_out (rnd_sig_out),
        .carry   (rnd_carry)
    );

    always_comb begin
        e_rnd        = rnd_carry ? (s1_exp_q + (EW+2)'(1)) : s1_exp_q;
        sig_rnd      = rnd_carry ? {1'b1, {MW{1'b0}}} : rnd_sig_out;
        inexact      = rnd_g | rnd_s;
        s2_valid_d   = s2_load ? s1_valid_q : s2_valid_q;
        out_result_d = out_result_q;
        out_flags_d  = out_flags_q;
        if (s2_load && s1_valid_q) begin
            out_flags_d = '0;
            if (s1_ctrl_q.status[ST_INVALID]) begin
                out_result_d            = QNAN;
                out_flags_d[FL_INVALID] = 1'b1;
                out_flags_d[FL_NAN]     = 1'b1;
            end else if (s1_ctrl_q.status[ST_NAN]) begin
                out_result_d        = QNAN;
                out_flags_d[FL_NAN] = 1'b1;
            end else if (s1_ctrl_q.status[ST_INF]) begin
                out_result_d = {s1_ctrl_q.sign, {EW{1'b1}}, {MW{1'b0}}};
            end else if (s1_ctrl_q.status[ST_ZERO]) begin
                out_result_d = {s1_ctrl_q.sign, {(RW-1){1'b0}}};
            end else if ($signed(e_rnd) >= $signed(E_MAX)) begin
                out_result_d             = {s1_ctrl_q.sign, {EW{1'b1}}, {MW{1'b0}}};
                out_flags_d[FL_OVERFLOW] = 1'b1;
                out_flags_d[FL_INEXACT]  = 1'b1;
`ifdef FP_MUL_SUBNORMAL_OUT_EN
            end else if (tiny) begin
                // Rounding up into the hidden bit promotes the result to the smallest normal.
                out_result_d = {s1_ctrl_q.sign, {(EW-1){1'b0}}, sig_rnd[MW], sig_rnd[MW-1:0]};
                out_flags_d[FL_UNDERFLOW] = inexact;
                out_flags_d[FL_INEXACT]   = inexact;
`else
            end else if (($signed(e_rnd) <= $signed(E_ZERO)) || !sig_rnd[MW]) begin
                out_result_d              = {s1_ctrl_q.sign, {(RW-1){1'b0}}};
                out_flags_d[FL_UNDERFLOW] = 1'b1;
                out_flags_d[FL_INEXACT]   = 1'b1;
`endif
            end else begin
                out_result_d            = {s1_ctrl_q.sign, e_rnd[EW-1:0], sig_rnd[MW-1:0]};
                out_flags_d[FL_INEXACT] = inexact;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q   <= 1'b0;
            s2_valid_q   <= 1'b0;
            s1_exp_q     <= '0;
            s1_sig_q     <= '0;
            s1_ctrl_q    <= '0;
            out_result_q <= '0;
            out_flags_q  <= '0;
        end else begin
            s1_valid_q   <= s1_valid_d;
            s2_valid_q   <= s2_valid_d;
            s1_exp_q     <= s1_exp_d;
            s1_sig_q     <= s1_sig_d;
            s1_ctrl_q    <= s1_ctrl_d;
            out_result_q <= out_result_d;
            out_flags_q  <= out_flags_d;
        end
    end

    assign out_valid  = s2_valid_q;
    assign out_result = out_result_q;
    assign out_flags  = out_flags_q;

endmodule

`default_nettype wire
